// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and defaults for the LEGv8 instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W      = 64;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned RD_WAIT_DEF = 2;
    localparam int unsigned PC_INC_DEF  = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory-side and decode/execute-side signals of the fetch stage.
interface instruction_fetch_unit_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0]  Address;
    logic [INSTR_W-1:0] MemData;
    logic [INSTR_W-1:0] Instr;
    logic [ADDR_W-1:0]  InstrPC;
    logic               InstrValid;
    logic               InstrReady;
    logic               RedirectValid;
    logic [ADDR_W-1:0]  RedirectPC;

    modport master (
        output Address, Instr, InstrPC, InstrValid,
        input  MemData, InstrReady, RedirectValid, RedirectPC
    );

    modport slave (
        input  Address, Instr, InstrPC, InstrValid,
        output MemData, InstrReady, RedirectValid, RedirectPC
    );

endinterface

// File: rtl/instruction_fetch_unit_wait_counter.sv
// Memory read-settle counter: counts up to TERM, then holds and flags terminal.
module fetch_wait_counter #(
    parameter int unsigned TERM = 1,
    parameter int unsigned W    = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == W'(TERM));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !term_o)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, waits RD_WAIT cycles per read, holds one word for decode.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned RD_WAIT = RD_WAIT_DEF,
    parameter int unsigned PC_INC  = PC_INC_DEF
) (
    input  logic                      CLK,
    input  logic                      resetl,
    input  logic [ADDR_W-1:0]         startPC,
    instruction_fetch_unit_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(RD_WAIT + 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic               valid_q, valid_d;
    logic               cnt_clr, cnt_en, cnt_term;
    logic               take;
    logic               xfer;

    assign xfer = valid_q & bus.InstrReady;

    fetch_wait_counter #(
        .TERM (RD_WAIT - 1),
        .W    (CNT_W)
    ) u_wait (
        .clk_i  (CLK),
        .rst_ni (resetl),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_o (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        take    = 1'b0;

        if (xfer)
            valid_d = 1'b0;

        case (state_q)
            BOOT: begin
                pc_d    = word_align(startPC);
                cnt_clr = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                if (!cnt_term)
                    cnt_en = 1'b1;
                else if (!valid_q || xfer)
                    take = 1'b1;
                else
                    state_d = FULL;
            end
            FULL: begin
                if (xfer) begin
                    take    = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase

        if (take) begin
            instr_d = bus.MemData;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(PC_INC);
            cnt_clr = 1'b1;
        end

        // Redirect overrides everything above, including a capture decided this cycle.
        if (bus.RedirectValid && state_q != BOOT) begin
            instr_d = instr_q;
            ipc_d   = ipc_q;
            valid_d = 1'b0;
            pc_d    = word_align(bus.RedirectPC);
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
            state_d = FETCH;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= BOOT;
            pc_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Address    = pc_q;
    assign bus.Instr      = instr_q;
    assign bus.InstrPC    = ipc_q;
    assign bus.InstrValid = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with RD_WAIT=2, PC_INC=4.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startPC;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(
        .RD_WAIT (2),
        .PC_INC  (4)
    ) dut (
        .CLK     (CLK),
        .resetl  (resetl),
        .startPC (startPC),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0)      return 32'hF84003E9;
        else if (a == 64'h4) return 32'hF84083EA;
        else                 return a[31:0] ^ 32'hD5030000;
    endfunction

    assign bus.MemData = mem_word(bus.Address);

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Leaves the bench 1 time unit after an edge; the next edge is boot edge 1.
    task automatic do_reset(input logic [63:0] sp);
        resetl            = 1'b0;
        startPC           = sp;
        bus.InstrReady    = 1'b1;
        bus.RedirectValid = 1'b0;
        bus.RedirectPC    = '0;
        tick(2);
        resetl = 1'b1;
    endtask

    task automatic test_reset;
        do_reset(64'h0);
        resetl = 1'b0;
        #2;
        n_cmp++;
        if ({bus.Address, bus.Instr, bus.InstrPC, bus.InstrValid} !== 161'b0) begin
            $display("FAIL reset_outputs: got A=%h I=%h PC=%h V=%b, need all zero",
                     bus.Address, bus.Instr, bus.InstrPC, bus.InstrValid);
            n_bad++;
        end
        resetl = 1'b1;
    endtask

    task automatic test_boot;
        do_reset(64'h0);
        tick(2);
        n_cmp++;
        if (bus.InstrValid !== 1'b0) begin
            $display("FAIL boot_early_valid: got %b need 0", bus.InstrValid);
            n_bad++;
        end
        tick(1);
        n_cmp++;
        if (bus.InstrValid !== 1'b1 || bus.Instr !== 32'hF84003E9 || bus.InstrPC !== 64'h0) begin
            $display("FAIL boot_first: got V=%b I=%h PC=%h need V=1 I=f84003e9 PC=0",
                     bus.InstrValid, bus.Instr, bus.InstrPC);
            n_bad++;
        end
        tick(1);
        n_cmp++;
        if (bus.InstrValid !== 1'b0) begin
            $display("FAIL boot_gap: got V=%b need 0", bus.InstrValid);
            n_bad++;
        end
        tick(1);
        n_cmp++;
        if (bus.InstrValid !== 1'b1 || bus.Instr !== 32'hF84083EA || bus.InstrPC !== 64'h4) begin
            $display("FAIL boot_second: got V=%b I=%h PC=%h need V=1 I=f84083ea PC=4",
                     bus.InstrValid, bus.Instr, bus.InstrPC);
            n_bad++;
        end
    endtask

    task automatic test_backpressure;
        do_reset(64'h0);
        tick(3);
        bus.InstrReady = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            tick(1);
            n_cmp++;
            if (bus.InstrValid !== 1'b1 || bus.Instr !== 32'hF84003E9 ||
                bus.InstrPC !== 64'h0 || bus.Address !== 64'h4) begin
                $display("FAIL bp_hold[%0d]: got V=%b I=%h PC=%h A=%h need V=1 I=f84003e9 PC=0 A=4",
                         i, bus.InstrValid, bus.Instr, bus.InstrPC, bus.Address);
                n_bad++;
            end
        end
        bus.InstrReady = 1'b1;
        tick(1);
        n_cmp++;
        if (bus.InstrValid !== 1'b1 || bus.Instr !== 32'hF84083EA ||
            bus.InstrPC !== 64'h4 || bus.Address !== 64'h8) begin
            $display("FAIL bp_release: got V=%b I=%h PC=%h A=%h need V=1 I=f84083ea PC=4 A=8",
                     bus.InstrValid, bus.Instr, bus.InstrPC, bus.Address);
            n_bad++;
        end
        tick(2);
        n_cmp++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 64'h8) begin
            $display("FAIL bp_after: got V=%b PC=%h need V=1 PC=8", bus.InstrValid, bus.InstrPC);
            n_bad++;
        end
    endtask

    task automatic test_redirect;
        do_reset(64'h0);
        tick(3);
        bus.InstrReady    = 1'b0;
        bus.RedirectValid = 1'b1;
        bus.RedirectPC    = 64'h1E;
        tick(1);
        bus.RedirectValid = 1'b0;
        bus.InstrReady    = 1'b1;
        n_cmp++;
        if (bus.InstrValid !== 1'b0 || bus.Address !== 64'h1C) begin
            $display("FAIL redir_flush: got V=%b A=%h need V=0 A=1c", bus.InstrValid, bus.Address);
            n_bad++;
        end
        tick(1);
        n_cmp++;
        if (bus.InstrValid !== 1'b0) begin
            $display("FAIL redir_wait: got V=%b need 0", bus.InstrValid);
            n_bad++;
        end
        tick(1);
        n_cmp++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 64'h1C || bus.Instr !== 32'hD503001C) begin
            $display("FAIL redir_target: got V=%b PC=%h I=%h need V=1 PC=1c I=d503001c",
                     bus.InstrValid, bus.InstrPC, bus.Instr);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] taken [$];
        do_reset(64'h0);
        tick(3);
        bus.RedirectValid = 1'b1;
        bus.RedirectPC    = 64'h40;
        for (int unsigned i = 0; i < 6; i++) begin
            if (bus.InstrValid && bus.InstrReady)
                taken.push_back(bus.InstrPC);
            tick(1);
            bus.RedirectValid = 1'b0;
        end
        n_cmp++;
        if (taken.size() !== 3) begin
            $display("FAIL simul_count: got %0d transfers need 3", taken.size());
            n_bad++;
        end else begin
            n_cmp++;
            if (taken[0] !== 64'h0 || taken[1] !== 64'h40 || taken[2] !== 64'h44) begin
                $display("FAIL simul_seq: got %h %h %h need 0 40 44", taken[0], taken[1], taken[2]);
                n_bad++;
            end
        end
    endtask

    task automatic test_wrap;
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        tick(3);
        n_cmp++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 64'hFFFF_FFFF_FFFF_FFFC || bus.Address !== 64'h0) begin
            $display("FAIL wrap_top: got V=%b PC=%h A=%h need V=1 PC=fffffffffffffffc A=0",
                     bus.InstrValid, bus.InstrPC, bus.Address);
            n_bad++;
        end
        tick(2);
        n_cmp++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 64'h0 || bus.Instr !== 32'hF84003E9) begin
            $display("FAIL wrap_zero: got V=%b PC=%h I=%h need V=1 PC=0 I=f84003e9",
                     bus.InstrValid, bus.InstrPC, bus.Instr);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid;
        do_reset(64'h100);
        tick(2);
        n_cmp++;
        if (bus.Address !== 64'h100) begin
            $display("FAIL mid_fetch_pre: got A=%h need 100", bus.Address);
            n_bad++;
        end
        resetl = 1'b0;
        #2;
        n_cmp++;
        if ({bus.Address, bus.Instr, bus.InstrPC, bus.InstrValid} !== 161'b0) begin
            $display("FAIL mid_fetch_reset: got A=%h I=%h PC=%h V=%b need all zero",
                     bus.Address, bus.Instr, bus.InstrPC, bus.InstrValid);
            n_bad++;
        end
        do_reset(64'h100);
        bus.InstrReady = 1'b0;
        tick(5);
        n_cmp++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 64'h100 || bus.Address !== 64'h104) begin
            $display("FAIL mid_full_pre: got V=%b PC=%h A=%h need V=1 PC=100 A=104",
                     bus.InstrValid, bus.InstrPC, bus.Address);
            n_bad++;
        end
        resetl = 1'b0;
        #2;
        n_cmp++;
        if ({bus.Address, bus.Instr, bus.InstrPC, bus.InstrValid} !== 161'b0) begin
            $display("FAIL mid_full_reset: got A=%h I=%h PC=%h V=%b need all zero",
                     bus.Address, bus.Instr, bus.InstrPC, bus.InstrValid);
            n_bad++;
        end
        do_reset(64'h4C);
        tick(3);
        n_cmp++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 64'h4C || bus.Instr !== 32'hD503004C) begin
            $display("FAIL reboot_first: got V=%b PC=%h I=%h need V=1 PC=4c I=d503004c",
                     bus.InstrValid, bus.InstrPC, bus.Instr);
            n_bad++;
        end
    endtask

    initial begin
        resetl            = 1'b0;
        startPC           = '0;
        bus.InstrReady    = 1'b0;
        bus.RedirectValid = 1'b0;
        bus.RedirectPC    = '0;
        test_reset();
        test_boot();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage sitting directly upstream of the instruction memory in the LEGv8 datapath. Owns the program counter, drives the 64-bit byte address into the instruction memory, waits a fixed number of cycles for the memory read to settle, and captures the 32-bit instruction word into a one-entry output register. It then presents the word to decode with a valid/ready handshake. Branch and CBZ outcomes from execute come back as a redirect that flushes any in-flight fetch.

## Interface
- RD_WAIT, 2: cycles Address is held stable before MemData is sampled; legal range 1..15.
- PC_INC, 4: sequential PC increment in bytes.
- CLK  in  1  sole clock, rising edge.
- resetl  in  1  asynchronous, active-low reset.
- startPC  in  64  boot address; sampled on the first rising edge after resetl deasserts.
- Address  out  64  fetch address to instruction memory; always equals the internal PC.
- MemData  in  32  instruction word returned by memory.
- Instr  out  32  captured instruction.
- InstrPC  out  64  byte address Instr was fetched from.
- InstrValid  out  1  Instr/InstrPC hold an unconsumed instruction.
- InstrReady  in  1  decode accepts; a transfer occurs on an edge where InstrValid and InstrReady are both high.
- RedirectValid  in  1  execute requests a PC change.
- RedirectPC  in  64  redirect target; bits [1:0] are forced to 0.

## Operation
- States: BOOT, FETCH, FULL.
- Reset (asynchronous): state=BOOT, PC=0, cnt=0, Instr=0, InstrPC=0, InstrValid=0.
- BOOT: on the next edge, PC<=startPC with bits [1:0] cleared, cnt<=0, state -> FETCH.
- FETCH: cnt increments each edge while cnt<RD_WAIT-1. Memory data is ready in the cycle where cnt==RD_WAIT-1.
  - If the slot is free in that cycle (InstrValid==0, or a transfer occurs): Instr<=MemData, InstrPC<=PC, InstrValid<=1, PC<=PC+PC_INC, cnt<=0, stay in FETCH.
  - Otherwise: state -> FULL. PC and Address are held.
- FULL: Address is held and MemData stays valid. On a transfer edge, capture as above, PC+=PC_INC, cnt<=0, state -> FETCH.
- A transfer with no capture in the same cycle clears InstrValid.
- Redirect has highest priority and is honoured in any state except BOOT, where it is ignored.
  - Effect: PC<=RedirectPC&~3, cnt<=0, InstrValid<=0, state -> FETCH. No capture happens that cycle.
  - A transfer in the same cycle still counts as consumed by decode.
- PC arithmetic is modulo 2^64: 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- MemData is passed through unmodified, including the all-X default the memory returns for unmapped addresses.
- Reset asserted mid-fetch or mid-hold immediately returns every output to its reset value. The pending word is discarded.

## Timing
- Address changes only on an edge; it is stable for at least RD_WAIT full cycles before being sampled.
- First InstrValid rises on edge 1+RD_WAIT after reset release: BOOT takes 1 edge, then RD_WAIT edges of FETCH.
- With InstrReady held high, steady throughput is one instruction per RD_WAIT cycles.
- First instruction after a redirect is valid RD_WAIT edges after the redirect edge.
- InstrValid never drops without a transfer, a redirect or a reset.
- Instr and InstrPC are stable while InstrValid=1 and InstrReady=0.
- Redirect-to-valid latency equals RD_WAIT. No combinational path from RedirectValid or InstrReady to any output.

## Structure
- Shared package (fetch_pkg):
  - state enum {BOOT, FETCH, FULL};
  - PC_INC default;
  - RD_WAIT default;
  - the 64-bit address and 32-bit instruction widths.
- Counter width: $clog2(RD_WAIT+1).
- One natural sub-module, fetch_wait_counter: a counter with clear, enable and a terminal flag.
- Everything else lives in the top module.

## Test plan
- **Boot:** memory model with RD_WAIT=2 returns 0xF84003E9@0x0 and 0xF84083EA@0x4; startPC=0, InstrReady=1.
  -> InstrValid rises on edge 3 with Instr=0xF84003E9 and InstrPC=0.
  -> Next word 0xF84083EA with InstrPC=4 two cycles later.
- **Backpressure:** hold InstrReady=0 for 6 cycles after the first valid.
  -> Instr stays 0xF84003E9 and Address stays 0x4 in FULL.
  -> On release, InstrPC=4 is presented on the transfer edge with no gap.
- **Redirect:** RedirectValid with RedirectPC=0x1E while InstrValid=1.
  -> InstrValid=0 on the next edge and Address=0x1C.
  -> InstrPC=0x1C valid 2 edges later.
- **Simultaneous events:** transfer and redirect on the same edge.
  -> Exactly one instruction consumed, then the redirect target is fetched; no duplicate and no skip.
- **Wrap-around:** startPC=0xFFFF_FFFF_FFFF_FFFC.
  -> InstrPC sequence is 0xFFFF_FFFF_FFFF_FFFC, then 0x0.
- **Reset mid-operation:** assert resetl=0 between edges during FETCH and during FULL.
  -> All outputs are zero immediately, before the next edge.
  -> Reboot from a new startPC=0x4C yields InstrPC=0x4C first.
